cordic_sched: RTL and testbench
===============================

# cordic_sched

Round-robin scheduler that shares one fully pipelined `cordic` sine/cosine core among NREQ requesters. It accepts angle requests through valid/ready handshakes and issues at most one angle per cycle into the core. It tracks each in-flight operation with a requester tag and returns the sine/cosine result to the originating requester. A flush sequence lets software quiesce the shared core before an angle-format or mode change.

## Interface
- `WIDTH`, 24: angle/sine/cosine word width; matches the `cordic` core.
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 24: `cordic` latency in cycles, from `angle_i` sampled to the matching `sine_o`/`cosine_o` valid.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in NREQ: per-requester request valid.
- `req_angle_i` in NREQ*WIDTH: packed angles; requester i uses bits [i*WIDTH +: WIDTH].
- `req_ready_o` out NREQ: one-hot grant; at most one bit high.
- `rsp_valid_o` out NREQ: one-hot, one-cycle result pulse; no backpressure.
- `rsp_sine_o` out WIDTH: result sine, shared by all requesters.
- `rsp_cosine_o` out WIDTH: result cosine, shared by all requesters.
- `cordic_angle_o` out WIDTH: drives `cordic.angle_i`.
- `cordic_sine_i` in WIDTH: from `cordic.sine_o`.
- `cordic_cosine_i` in WIDTH: from `cordic.cosine_o`.
- `flush_i` in 1: level request to quiesce the core.
- `flush_done_o` out 1: one-cycle pulse when the pipeline is empty after a flush.
- `busy_o` out 1: high while any operation is in flight.

## Operation
- FSM states: RUN, DRAIN, DONE. Reset state is RUN.
- RUN:
  - `req_ready_o[i]` is high only for the winning requester. The winner is the first requester with valid high, searching upward (with wrap) from the one after the last granted requester.
  - Transfer occurs when valid and ready are both high.
  - `flush_i` high moves the FSM to DRAIN. Grants are already suppressed in the same cycle that `flush_i` is high.
- DRAIN:
  - No grants are issued.
  - When the tag pipe holds no valid entries, the FSM moves to DONE.
- DONE:
  - `flush_done_o` is high for one cycle.
  - Next state is DRAIN if `flush_i` is still high, otherwise RUN.
  - If `flush_i` stays high, the FSM alternates DRAIN/DONE with an empty pipe. `flush_done_o` then pulses every second cycle; this is the accepted behaviour.
- Issue register:
  - On a transfer, `cordic_angle_o` takes the granted angle.
  - Tag entry {valid=1, id} enters the tag pipe.
  - With no transfer, `cordic_angle_o` holds its value and a {valid=0} entry enters.
- Tag pipe: LAT-deep shift register of {valid, id[$clog2(NREQ)-1:0]}, aligned so that its output matches `cordic_sine_i`/`cordic_cosine_i`.
- Response register:
  - `rsp_sine_o`/`rsp_cosine_o` capture the core outputs every cycle.
  - `rsp_valid_o` = onehot(id) & valid, taken from the tag-pipe output.
- Round-robin pointer: updates only on a transfer. There is no starvation; every valid requester is served within NREQ transfers.
- `busy_o` = OR of all tag-pipe valid bits.
- Reset mid-operation: all tags are cleared. In-flight results are discarded and no `rsp_valid_o` pulses are produced for them.

## Timing
- Reset values: `req_ready_o`=0, `rsp_valid_o`=0, `rsp_sine_o`=0, `rsp_cosine_o`=0, `cordic_angle_o`=0, `flush_done_o`=0, `busy_o`=0. After reset the FSM is in RUN.
- `req_ready_o` is combinational from `req_valid_i`, the round-robin pointer, the FSM state and `flush_i`.
- Latency: transfer in cycle T gives the `rsp_valid_o` pulse in cycle T+LAT+2 (1 cycle issue register, LAT cycles core, 1 cycle response register).
- Throughput: 1 result per cycle.
- Results return in issue order.
- Flush: `flush_done_o` follows the last in-flight response by at most 2 cycles. A flush raised with an empty pipe gives `flush_done_o` 2 cycles later.

## Configuration
- `CORDIC_SCHED_STATS_EN`: when defined, adds output `issue_cnt_o` (NREQ*16 bits).
  - Holds one saturating 16-bit count of accepted transfers per requester.
  - Reset value is 0; counters also clear in the DONE state.
- When not defined, the port and counters are absent and behaviour is otherwise identical.

## Structure
- `cordic_sched_pkg` holds:
  - the WIDTH default;
  - the FSM state typedef (RUN, DRAIN, DONE);
  - a tag struct typedef {valid, id}.
- Sub-module `rr_arbiter`, parameterised by NREQ.
  - Inputs: request vector, advance enable.
  - Outputs: one-hot grant.
  - Owns the round-robin pointer.
- The top level holds the FSM, issue register, tag pipe, response register and stats counters.

## Test plan
- Single request: requester 2 sends 0x155555 (30°) at cycle 10.
  - `cordic_angle_o`=0x155555 at cycle 11.
  - `rsp_valid_o`=4'b0100 at cycle 10+LAT+2; sine ≈ 0.5 full scale.
- All four valid continuously for 40 cycles: grants rotate 0,1,2,3,0,…, and each requester gets exactly 10 transfers.
- Back-to-back angles 0x000000, 0x400000, 0x800000, 0xC00000 from requester 0 (0°, 90°, 180°, 270°): four consecutive `rsp_valid_o`=4'b0001 pulses, in order, with cosine ≈ +1, 0, −1, 0.
- Flush with 5 operations in flight:
  - No grants from the `flush_i` cycle on.
  - All 5 responses are delivered, then `flush_done_o` pulses once.
  - Normal granting resumes after `flush_i` drops.
- Assert `reset_n` low with 10 operations in flight: all outputs go to 0 immediately; no `rsp_valid_o` pulse appears after release.
- With `CORDIC_SCHED_STATS_EN` defined: 70000 transfers on requester 1 leave count 1 at 0xFFFF (saturated) and count 0 at 0.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
// Shared types for the cordic_sched scheduler: FSM states, in-flight tag format
// and a one-hot encoder sized for the largest supported requester count.
package cordic_sched_pkg;

  localparam int WIDTH_DEF = 24;
  localparam int NREQ_MAX  = 8;
  localparam int TAG_IDW   = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic logic [TAG_IDW-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
    logic [TAG_IDW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (oh[i]) idx = TAG_IDW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward (with wrap) from the requester after the
// last granted one; the pointer moves only when the grant is actually taken.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] grant_o
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] win;
  logic           found;
  int             idx;

  always_comb begin
    grant_o = '0;
    win     = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        win          = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) ptr_d = win;
  end

  // Pointer starts at the last requester so requester 0 is searched first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= IDW'(NREQ - 1);
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one pipelined cordic core among NREQ requesters with tag tracking and
// a flush/quiesce sequence. Optional per-requester counters: CORDIC_SCHED_STATS_EN.
module cordic_sched
  import cordic_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = 4,
  parameter int LAT   = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_angle_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic [NREQ-1:0]       rsp_valid_o,
  output logic [WIDTH-1:0]      rsp_sine_o,
  output logic [WIDTH-1:0]      rsp_cosine_o,
  output logic [WIDTH-1:0]      cordic_angle_o,
  input  logic [WIDTH-1:0]      cordic_sine_i,
  input  logic [WIDTH-1:0]      cordic_cosine_i,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic                  busy_o
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]    issue_cnt_o
`endif
);

  state_e                 state_q, state_d;
  logic [NREQ-1:0]        grant;
  logic                   grant_en;
  logic                   xfer;
  logic [WIDTH-1:0]       angle_q, angle_d;
  tag_t                   issue_tag_q, issue_tag_d;
  tag_t [LAT-1:0]         pipe_q, pipe_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]       rsp_sine_q, rsp_cosine_q;

  // Holding grants while reset is low keeps the handshake quiet during reset.
  assign grant_en    = (state_q == ST_RUN) && !flush_i && reset_n;
  assign req_ready_o = grant & {NREQ{grant_en}};
  assign xfer        = |req_ready_o;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (req_valid_i),
    .adv_i   (grant_en),
    .grant_o (grant)
  );

  always_comb begin
    busy_o = issue_tag_q.valid;
    for (int k = 0; k < LAT; k++) busy_o = busy_o | pipe_q[k].valid;
  end

  always_comb begin
    state_d      = state_q;
    flush_done_o = 1'b0;
    case (state_q)
      ST_RUN:   if (flush_i) state_d = ST_DRAIN;
      ST_DRAIN: if (!busy_o) state_d = ST_DONE;
      ST_DONE: begin
        flush_done_o = 1'b1;
        state_d      = flush_i ? ST_DRAIN : ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    angle_d           = angle_q;
    issue_tag_d.valid = xfer;
    issue_tag_d.id    = onehot_to_idx(NREQ_MAX'(req_ready_o));
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready_o[i]) angle_d = req_angle_i[i*WIDTH +: WIDTH];
    end
  end

  // The issue stage plus LAT pipe stages line the tag up with the core output.
  always_comb begin
    pipe_d[0] = issue_tag_q;
    for (int k = 1; k < LAT; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid_d[i] = pipe_q[LAT-1].valid && (pipe_q[LAT-1].id == TAG_IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      angle_q      <= '0;
      issue_tag_q  <= '0;
      pipe_q       <= '0;
      rsp_valid_q  <= '0;
      rsp_sine_q   <= '0;
      rsp_cosine_q <= '0;
    end else begin
      state_q      <= state_d;
      angle_q      <= angle_d;
      issue_tag_q  <= issue_tag_d;
      pipe_q       <= pipe_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_sine_q   <= cordic_sine_i;
      rsp_cosine_q <= cordic_cosine_i;
    end
  end

  assign cordic_angle_o = angle_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_sine_o     = rsp_sine_q;
  assign rsp_cosine_o   = rsp_cosine_q;

`ifdef CORDIC_SCHED_STATS_EN
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
      logic [15:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_DONE)                      cnt_d = '0;
        else if (req_ready_o[gi] && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end

      assign issue_cnt_o[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched: a behavioural LAT-stage core model and a
// scoreboard queue of issued requests checked against every response pulse.
module tb_cordic_sched;

  localparam int WIDTH = 24;
  localparam int NREQ  = 4;
  localparam int LAT   = 24;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req_valid_i = '0;
  logic [NREQ*WIDTH-1:0] req_angle_i = '0;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ-1:0]       rsp_valid_o;
  logic [WIDTH-1:0]      rsp_sine_o, rsp_cosine_o, cordic_angle_o;
  logic [WIDTH-1:0]      cordic_sine_i, cordic_cosine_i;
  logic                  flush_i = 1'b0;
  logic                  flush_done_o, busy_o;
`ifdef CORDIC_SCHED_STATS_EN
  logic [NREQ*16-1:0]    issue_cnt;
`endif

  always #5 clk = ~clk;

  cordic_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid_i     (req_valid_i),
    .req_angle_i     (req_angle_i),
    .req_ready_o     (req_ready_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_sine_o      (rsp_sine_o),
    .rsp_cosine_o    (rsp_cosine_o),
    .cordic_angle_o  (cordic_angle_o),
    .cordic_sine_i   (cordic_sine_i),
    .cordic_cosine_i (cordic_cosine_i),
    .flush_i         (flush_i),
    .flush_done_o    (flush_done_o),
    .busy_o          (busy_o)
`ifdef CORDIC_SCHED_STATS_EN
    ,
    .issue_cnt_o     (issue_cnt)
`endif
  );

  function automatic logic [WIDTH-1:0] model_sin(input logic [WIDTH-1:0] a);
    real r;
    r = $sin(6.283185307179586 * real'(a) / 16777216.0);
    return WIDTH'($rtoi(r * 4194304.0));
  endfunction

  function automatic logic [WIDTH-1:0] model_cos(input logic [WIDTH-1:0] a);
    real r;
    r = $cos(6.283185307179586 * real'(a) / 16777216.0);
    return WIDTH'($rtoi(r * 4194304.0));
  endfunction

  // Behavioural core: angle sampled each edge, result out LAT edges later.
  logic [WIDTH-1:0] core_q [LAT];
  always @(posedge clk) begin
    core_q[0] <= cordic_angle_o;
    for (int k = 1; k < LAT; k++) core_q[k] <= core_q[k-1];
  end
  assign cordic_sine_i   = model_sin(core_q[LAT-1]);
  assign cordic_cosine_i = model_cos(core_q[LAT-1]);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int               id;
    logic [WIDTH-1:0] angle;
    int               t;
  } exp_t;

  exp_t             sb[$];
  int               grant_log[$];
  int               cyc = 0;
  int               done_cnt = 0;
  logic             prev_xfer = 1'b0;
  logic [WIDTH-1:0] prev_angle = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      automatic logic [NREQ-1:0] xf = req_ready_o & req_valid_i;
      automatic exp_t e;
      if (prev_xfer) check("issue_angle", longint'(cordic_angle_o), longint'(prev_angle));
      if (req_ready_o != '0) check("ready_onehot", longint'($countones(req_ready_o)), 1);
      prev_xfer <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (xf[i]) begin
          e.id    = i;
          e.angle = req_angle_i[i*WIDTH +: WIDTH];
          e.t     = cyc;
          sb.push_back(e);
          grant_log.push_back(i);
          prev_xfer  <= 1'b1;
          prev_angle <= e.angle;
        end
      end
      if (rsp_valid_o != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", longint'(rsp_valid_o), 0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", longint'(rsp_valid_o), longint'(1 << e.id));
          check("rsp_latency", longint'(cyc), longint'(e.t + LAT + 2));
          check("rsp_sine", longint'(rsp_sine_o), longint'(model_sin(e.angle)));
          check("rsp_cosine", longint'(rsp_cosine_o), longint'(model_cos(e.angle)));
        end
      end
      if (flush_done_o) done_cnt <= done_cnt + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [WIDTH-1:0] a);
    automatic logic ok = 1'b0;
    req_angle_i[id*WIDTH +: WIDTH] = a;
    req_valid_i[id] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready_o[id]) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_granted", longint'(ok), 1);
    @(posedge clk);
    #1;
    req_valid_i[id] = 1'b0;
  endtask

  task automatic check_all_zero();
    check("rst_ready", longint'(req_ready_o), 0);
    check("rst_rsp_valid", longint'(rsp_valid_o), 0);
    check("rst_sine", longint'(rsp_sine_o), 0);
    check("rst_cosine", longint'(rsp_cosine_o), 0);
    check("rst_angle", longint'(cordic_angle_o), 0);
    check("rst_flush_done", longint'(flush_done_o), 0);
    check("rst_busy", longint'(busy_o), 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    idle(3);
    check("drain_empty", longint'(sb.size()), 0);
    check("drain_busy", longint'(busy_o), 0);
  endtask

  initial begin
    int cnt[NREQ];
    int d0;
    logic got;

    req_valid_i = '1;
    #2;
    check_all_zero();
    req_valid_i = '0;
    idle(3);
    reset_n = 1'b1;
    idle(3);

    // All four requesters valid for 40 cycles: strict rotation starting at 0.
    for (int i = 0; i < NREQ; i++) req_angle_i[i*WIDTH +: WIDTH] = WIDTH'(24'h080000 * (i + 1));
    grant_log.delete();
    req_valid_i = '1;
    idle(40);
    req_valid_i = '0;
    check("busy_inflight", longint'(busy_o), 1);
    check("rot_count", longint'(grant_log.size()), 40);
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    foreach (grant_log[k]) begin
      check("rot_order", longint'(grant_log[k]), longint'(k % NREQ));
      if (grant_log[k] < NREQ) cnt[grant_log[k]]++;
    end
    for (int i = 0; i < NREQ; i++) check("rot_per_req", longint'(cnt[i]), 10);
    drain();

    // Single request from requester 2 (30 degrees).
    idle(10);
    send(2, 24'h155555);
    drain();

    // Back-to-back quadrant angles from requester 0.
    send(0, 24'h000000);
    send(0, 24'h400000);
    send(0, 24'h800000);
    send(0, 24'hC00000);
    drain();

    // Flush with five operations in flight.
    for (int k = 0; k < 5; k++) send(1, WIDTH'(24'h100000 + k * 24'h011111));
    check("flush_inflight", longint'(sb.size()), 5);
    req_angle_i[3*WIDTH +: WIDTH] = 24'h2AAAAA;
    req_valid_i[3] = 1'b1;
    flush_i = 1'b1;
    d0  = done_cnt;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      check("flush_no_grant", longint'(req_ready_o), 0);
      if (flush_done_o) begin
        got = 1'b1;
        flush_i = 1'b0;
        break;
      end
    end
    check("flush_done_seen", longint'(got), 1);
    check("flush_drained", longint'(sb.size()), 0);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready_o[3]) begin
        got = 1'b1;
        break;
      end
    end
    check("flush_resume", longint'(got), 1);
    @(posedge clk);
    #1;
    req_valid_i[3] = 1'b0;
    idle(10);
    check("flush_done_pulses", longint'(done_cnt - d0), 1);
    drain();

    // Reset with ten operations in flight.
    req_valid_i = '1;
    idle(10);
    req_valid_i = '0;
    idle(2);
    check("prereset_busy", longint'(busy_o), 1);
    req_valid_i = '1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_all_zero();
    idle(3);
    req_valid_i = '0;
    reset_n = 1'b1;
    idle(LAT + 10);
    check("postreset_busy", longint'(busy_o), 0);

`ifdef CORDIC_SCHED_STATS_EN
    check("stats_reset", longint'(issue_cnt[31:16]), 0);
    req_angle_i[1*WIDTH +: WIDTH] = 24'h123456;
    req_valid_i[1] = 1'b1;
    idle(100);
    req_valid_i[1] = 1'b0;
    idle(1);
    check("stats_cnt100", longint'(issue_cnt[31:16]), 100);
    req_valid_i[1] = 1'b1;
    idle(69900);
    req_valid_i[1] = 1'b0;
    drain();
    check("stats_sat", longint'(issue_cnt[31:16]), 16'hFFFF);
    check("stats_other", longint'(issue_cnt[15:0]), 0);
`endif

    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
